// File: rtl/fib_member_check.sv
// Sequential Fibonacci membership checker: walks the sequence one term per clock and reports
// membership, the matching/lower index and the largest term not exceeding the latched operand.
module fib_member_check #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_i,
  input  logic [WIDTH-1:0] number,
  output logic             result,
  output logic             done,
  output logic             busy,
  output logic [IDX_W-1:0] fib_index,
  output logic [WIDTH-1:0] fib_lower,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    StIdle         = 4'd0,
    StIter         = 4'd1,
    StDoneFound    = 4'd7,
    StDoneNotFound = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             result_q, result_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic [WIDTH:0]   n_ext;

  // Terms are one bit wider than the operand so b can exceed any WIDTH-bit n without wrapping.
  assign n_ext = {1'b0, n_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    index_d  = index_q;
    lower_d  = lower_q;
    case (state_q)
      StIdle: begin
        if (go_i) begin
          n_d     = number;
          a_d     = '0;
          b_d     = {{WIDTH{1'b0}}, 1'b1};
          k_d     = '0;
          state_d = StIter;
        end
      end
      StIter: begin
        if (a_q == n_ext) begin
          result_d = 1'b1;
          index_d  = k_q;
          lower_d  = a_q[WIDTH-1:0];
          state_d  = StDoneFound;
        end else if (b_q > n_ext) begin
          result_d = 1'b0;
          index_d  = k_q;
          lower_d  = a_q[WIDTH-1:0];
          state_d  = StDoneNotFound;
        end else begin
          a_d = b_q;
          b_d = a_q + b_q;
          k_d = k_q + IDX_W'(1);
        end
      end
      StDoneFound, StDoneNotFound: begin
        if (!go_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= 1'b0;
      index_q  <= '0;
      lower_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      index_q  <= index_d;
      lower_q  <= lower_d;
    end
  end

  assign result    = result_q;
  assign fib_index = index_q;
  assign fib_lower = lower_q;
  assign state     = state_q;
  assign busy      = (state_q == StIter);
  assign done      = (state_q == StDoneFound) || (state_q == StDoneNotFound);

endmodule

// File: tb/tb_fib_member_check.sv
// Directed bench for fib_member_check: hand-computed Fibonacci results, latency, reset and
// operand-latching behaviour.
module tb_fib_member_check;

  logic        clk;
  logic        reset;
  logic        go_i;
  logic [31:0] number;
  logic        result;
  logic        done;
  logic        busy;
  logic [6:0]  fib_index;
  logic [31:0] fib_lower;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;
  int cycles;

  fib_member_check #(
    .WIDTH(32),
    .IDX_W(7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .go_i     (go_i),
    .number   (number),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .fib_index(fib_index),
    .fib_lower(fib_lower),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept num on the next edge, then count sampled ITER cycles until busy drops.
  task automatic run(input logic [31:0] num, output int cyc);
    number = num;
    go_i   = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk("timeout", 64'(busy), 64'd0);
  endtask

  task automatic to_idle();
    go_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    go_i   = 1'b0;
    number = '0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_index", 64'(fib_index), 64'd0);
    chk("rst_lower", 64'(fib_lower), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_hold", 64'(state), 64'd0);

    // 89 = F11: twelve ITER cycles, then found.
    run(32'd89, cycles);
    chk("f89_cycles", 64'(cycles), 64'd12);
    chk("f89_state", 64'(state), 64'd7);
    chk("f89_result", 64'(result), 64'd1);
    chk("f89_index", 64'(fib_index), 64'd11);
    chk("f89_lower", 64'(fib_lower), 64'd89);
    chk("f89_done", 64'(done), 64'd1);
    chk("f89_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("f89_no_restart", 64'(state), 64'd7);
    to_idle();
    chk("f89_idle", 64'(state), 64'd0);
    chk("f89_idle_done", 64'(done), 64'd0);
    chk("f89_idle_result_held", 64'(result), 64'd1);
    chk("f89_idle_index_held", 64'(fib_index), 64'd11);

    // 4 lies between F4=3 and F5=5.
    run(32'd4, cycles);
    chk("f4_state", 64'(state), 64'd8);
    chk("f4_result", 64'(result), 64'd0);
    chk("f4_index", 64'(fib_index), 64'd4);
    chk("f4_lower", 64'(fib_lower), 64'd3);
    chk("f4_done", 64'(done), 64'd1);
    to_idle();
    chk("f4_idle", 64'(state), 64'd0);

    // 0 then 1, reaccepted right after IDLE.
    run(32'd0, cycles);
    chk("f0_cycles", 64'(cycles), 64'd1);
    chk("f0_state", 64'(state), 64'd7);
    chk("f0_index", 64'(fib_index), 64'd0);
    chk("f0_lower", 64'(fib_lower), 64'd0);
    to_idle();
    run(32'd1, cycles);
    chk("f1_cycles", 64'(cycles), 64'd2);
    chk("f1_result", 64'(result), 64'd1);
    chk("f1_index", 64'(fib_index), 64'd1);
    chk("f1_lower", 64'(fib_lower), 64'd1);
    to_idle();

    // 100 lies between F11=89 and F12=144.
    run(32'd100, cycles);
    chk("f100_result", 64'(result), 64'd0);
    chk("f100_index", 64'(fib_index), 64'd11);
    chk("f100_lower", 64'(fib_lower), 64'd89);
    to_idle();

    // Full-width operand: F47 is the largest 32-bit term.
    run(32'hFFFF_FFFF, cycles);
    chk("fmax_cycles", 64'(cycles), 64'd48);
    chk("fmax_state", 64'(state), 64'd8);
    chk("fmax_result", 64'(result), 64'd0);
    chk("fmax_index", 64'(fib_index), 64'd47);
    chk("fmax_lower", 64'(fib_lower), 64'd2971215073);
    to_idle();

    // Asynchronous reset in the middle of a run.
    number = 32'd89;
    go_i   = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_index", 64'(fib_index), 64'd0);
    chk("arst_lower", 64'(fib_lower), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run(32'd89, cycles);
    chk("post_rst_cycles", 64'(cycles), 64'd12);
    chk("post_rst_result", 64'(result), 64'd1);
    chk("post_rst_index", 64'(fib_index), 64'd11);
    to_idle();

    // Operand and go_i disturbed during ITER: 21 = F8 is what counts.
    number = 32'd21;
    go_i   = 1'b1;
    @(negedge clk);
    number = 32'd100;
    go_i   = 1'b0;
    @(negedge clk);
    number = 32'd7;
    go_i   = 1'b1;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    chk("latch_state", 64'(state), 64'd7);
    chk("latch_result", 64'(result), 64'd1);
    chk("latch_index", 64'(fib_index), 64'd8);
    chk("latch_lower", 64'(fib_lower), 64'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
